// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// the default address/data widths agreed between cores, memory and arbiter.
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } arb_state_t;

  // Grant index width: ceil(log2(n)), never narrower than one bit.
  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin selection: the first requester found searching
// upward from last_grant+1, wrapping modulo NUM_CORES.
module rr_picker #(
  parameter int NUM_CORES = 2,
  parameter int GID_W     = 1
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [GID_W-1:0]     last_grant,
  output logic                 found,
  output logic [GID_W-1:0]     winner
);

  // cand_idx[d] is the core sitting d+1 positions after last_grant
  logic [GID_W-1:0]     cand_idx [NUM_CORES];
  logic [NUM_CORES-1:0] cand_hit;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_cand
      assign cand_idx[gi] = GID_W'((int'(last_grant) + gi + 1) % NUM_CORES);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the nearest candidate is assigned last and wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int d = NUM_CORES - 1; d >= 0; d--) begin
      if (cand_hit[d]) begin
        found  = 1'b1;
        winner = cand_idx[d];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_CORES
// cores. Define DMEM_ARB_STATS_EN to add the contention_count output.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int GID_W     = gid_width(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic [GID_W-1:0]            grant_id
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]                 contention_count
`endif
);

  arb_state_t state_reg, state_next;

  logic [GID_W-1:0]     gid_reg;
  logic [GID_W-1:0]     last_grant_reg;
  logic                 we_reg;
  logic [ADDR_W-1:0]    addr_reg;
  logic [DATA_W-1:0]    wdata_reg;
  logic [DATA_W-1:0]    rdata_reg;
  logic                 read_reg, read_next;
  logic                 write_reg, write_next;
  logic                 busy_reg, busy_next;
  logic [NUM_CORES-1:0] ack_reg, ack_next;

  logic                 pick_found;
  logic [GID_W-1:0]     pick_winner;
  logic                 sel_we;
  logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
  logic [DATA_W-1:0]    wdata_arr [NUM_CORES];

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
      assign addr_arr[gi]  = core_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = core_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_picker #(
    .NUM_CORES (NUM_CORES),
    .GID_W     (GID_W)
  ) u_picker (
    .req        (core_req),
    .last_grant (last_grant_reg),
    .found      (pick_found),
    .winner     (pick_winner)
  );

  assign sel_we = core_we[pick_winner];

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Requests are only looked at in IDLE; ACK always falls back to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (pick_found) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = we_reg ? ST_ACK : ST_CAPTURE;
      ST_CAPTURE: state_next = ST_ACK;
      ST_ACK:     state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they land in registers
  // and line up with the state they belong to.
  always_comb begin
    busy_next  = (state_next != ST_IDLE);
    read_next  = 1'b0;
    write_next = 1'b0;
    ack_next   = '0;
    if (state_next == ST_ISSUE) begin
      read_next  = !sel_we;
      write_next = sel_we;
    end
    if (state_next == ST_ACK) begin
      ack_next[gid_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      gid_reg        <= '0;
      last_grant_reg <= GID_W'(NUM_CORES - 1);
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      read_reg       <= 1'b0;
      write_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      ack_reg        <= '0;
    end else begin
      read_reg  <= read_next;
      write_reg <= write_next;
      busy_reg  <= busy_next;
      ack_reg   <= ack_next;
      if (state_reg == ST_IDLE && pick_found) begin
        gid_reg        <= pick_winner;
        last_grant_reg <= pick_winner;
        we_reg         <= sel_we;
        addr_reg       <= addr_arr[pick_winner];
        wdata_reg      <= wdata_arr[pick_winner];
      end
      // mem_rdata is valid the cycle after the read strobe, i.e. in CAPTURE
      if (state_reg == ST_CAPTURE) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  assign core_ack   = ack_reg;
  assign core_rdata = rdata_reg;
  assign mem_read   = read_reg;
  assign mem_write  = write_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign busy       = busy_reg;
  assign grant_id   = gid_reg;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] contention_reg;
  logic        multi_req;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_req = |(core_req & (core_req - NUM_CORES'(1)));

  always_ff @(posedge clk) begin
    if (RESET) begin
      contention_reg <= '0;
    end else if (state_reg == ST_IDLE && multi_req && contention_reg != 16'hFFFF) begin
      contention_reg <= contention_reg + 16'd1;
    end
  end

  assign contention_count = contention_reg;
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 16-bit data memory among `NUM_CORES` matrix-multiplication processor cores.
- Each core raises a request with address, write data and direction.
- The arbiter grants one core at a time, round-robin.
- It drives the memory's read and write strobes, then returns an acknowledge and the read data.
- It sits between the cores' data-memory ports and the data memory inside `top`, in place of a direct core-to-memory connection.

## Interface
- `NUM_CORES`, 2: number of requesting cores (2–8).
- `ADDR_W`, 16: memory address width (matches AR).
- `DATA_W`, 16: memory data width.
- `GID_W`, `$clog2(NUM_CORES)` (min 1): width of the grant index.

Ports:
- `clk` in 1: single system clock; all state updates on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `core_req` in `NUM_CORES`: per-core request; held high until acknowledged.
- `core_we` in `NUM_CORES`: 1 = write, 0 = read; stable while the request is high.
- `core_addr` in `NUM_CORES*ADDR_W`: flattened addresses; core k occupies bits `[k*ADDR_W +: ADDR_W]`.
- `core_wdata` in `NUM_CORES*DATA_W`: flattened write data, same packing.
- `core_ack` out `NUM_CORES`: one-cycle acknowledge to the granted core.
- `core_rdata` out `DATA_W`: read data; valid in the cycle `core_ack` is high and the access was a read.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_rdata` in `DATA_W`: memory read data; valid one cycle after `mem_read`.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out `GID_W`: index of the core currently granted.

## Operation
- The FSM has four states: IDLE, ISSUE, CAPTURE, ACK.
- **IDLE:** if any `core_req` bit is high, select a winner.
  - The winner is the first requester found searching from `last_grant+1`, wrapping modulo `NUM_CORES`.
  - Register the winner's index, `we`, address and wdata. Set `last_grant` to the winner. Go to ISSUE.
  - If no request is high, stay in IDLE.
- **ISSUE:** drive `mem_addr`/`mem_wdata` from the registered values.
  - Assert `mem_read` for a read or `mem_write` for a write, for exactly this one cycle.
  - Next state: CAPTURE for a read, ACK for a write.
- **CAPTURE:** register `mem_rdata` into `core_rdata`. Go to ACK.
- **ACK:** assert `core_ack[grant_id]` for one cycle, then return to IDLE.
  - `core_req` is ignored while in this state.
- Requester protocol:
  - A core deasserts its request on the edge where it samples `core_ack` high.
  - It may re-request from the next cycle.
  - A core must not change `we`/addr/wdata while its request is pending.
- `core_rdata` holds its last captured value until the next read capture.
  - `core_rdata` is not updated by writes.
- Requests arriving while the FSM is not in IDLE wait; they are not lost, because requests are level-held.
- Reset values:
  - FSM state: IDLE.
  - `core_ack`, `mem_read`, `mem_write`, `busy`: 0.
  - `mem_addr`, `mem_wdata`, `core_rdata`, `grant_id`: 0.
  - `last_grant`: `NUM_CORES-1`, so core 0 wins first after reset.
- Reset mid-operation: the FSM returns to IDLE at that edge and the strobes drop.
  - No acknowledge is issued for the aborted access.
  - Still-pending requests are re-arbitrated after reset is released.
- Simultaneous requests: exactly one is granted per arbitration. With all cores requesting continuously, grants rotate 0,1,…,N-1,0.

## Timing
- All outputs are registered; no combinational path from `core_*` inputs to `mem_*` outputs.
- With the request sampled in IDLE at edge n:
  - ISSUE occupies cycle n+1.
  - For a read, CAPTURE occupies cycle n+2 and ACK cycle n+3: 3-cycle latency.
  - For a write, ACK occupies cycle n+2: 2-cycle latency.
- Throughput, including the IDLE cycle: 4 cycles per read, 3 per write.
- `busy` is high from ISSUE through ACK inclusive.
- `grant_id` is stable from ISSUE through ACK.

## Configuration
- `DMEM_ARB_STATS_EN`: when defined, the block adds output `contention_count` (16-bit).
  - The count increments each IDLE cycle in which two or more `core_req` bits are high.
  - It saturates at 0xFFFF and resets to 0.
- When `DMEM_ARB_STATS_EN` is undefined, the port and the counter logic are absent. Arbitration behaviour is identical either way.

## Structure
- Shared package/header holds:
  - the state encodings: IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, ACK = 2'd3;
  - the default `ADDR_W`/`DATA_W` = 16, so cores, memory and arbiter agree.
- One sub-module, `rr_picker`: combinational round-robin selection.
  - Inputs: the request vector and `last_grant`.
  - Outputs: `found` and `winner` index.
- The FSM and registers live in `dmem_arbiter`.

## Test plan
- Reset, then a single core 0 read of addr 0x0010 with memory holding 0x00AB.
  - `mem_read` is high for exactly 1 cycle with `mem_addr` = 0x0010.
  - `core_ack[0]` is high 3 cycles after the request is sampled, with `core_rdata` = 0x00AB.
- Core 1 write of 0x1234 to 0x0020.
  - `mem_write` is high for 1 cycle with addr 0x0020 and data 0x1234.
  - `core_ack[1]` is high 2 cycles after the request is sampled. `core_rdata` is unchanged.
- Both cores request reads continuously for 8 transactions: grants alternate 0,1,0,1,…
  - No ack goes to a non-requester.
  - Exactly one `mem_*` strobe is high per transaction.
- `RESET` is pulsed during the CAPTURE of a core 0 read: no `core_ack` is issued.
  - All outputs return to 0 at that edge.
  - The next grant after release goes to core 0.
- With `DMEM_ARB_STATS_EN` defined, 3 contended arbitrations followed by 1 uncontended: `contention_count` = 3.
  - Forcing 70000 contended arbitrations leaves `contention_count` at 0xFFFF.
